// File: rtl/sort_pkg.sv
// Shared constants and types for the sort/merge stream blocks.
package sort_pkg;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  typedef logic [WIDTH-1:0] word_t;
  typedef logic [2:0]       ptr_t;

  // Pointer value meaning "this block is exhausted".
  localparam ptr_t PTR_END = 3'(DEPTH);

  // FSM encoding.
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_MERGE = 1'b1;

endpackage

// File: rtl/sort_merge_stream_merge_pick.sv
// Combinational two-way merge selector: picks the next word from the heads
// of blocks A and B. Ties go to A so equal keys keep their A-before-B order.
module merge_pick
  import sort_pkg::*;
(
  input  logic [WIDTH-1:0] cand_a,
  input  logic [WIDTH-1:0] cand_b,
  input  logic             a_done,
  input  logic             b_done,
  output logic [WIDTH-1:0] word,
  output logic             src
);

  // Select rule: exhausted source loses, otherwise unsigned <= favours A.
  always_comb begin
    word = cand_a;
    src  = 1'b0;
    if (a_done) begin
      word = cand_b;
      src  = 1'b1;
    end else if (b_done) begin
      word = cand_a;
      src  = 1'b0;
    end else if (cand_a <= cand_b) begin
      word = cand_a;
      src  = 1'b0;
    end else begin
      word = cand_b;
      src  = 1'b1;
    end
  end

endmodule

// File: rtl/sort_merge_stream.sv
// Accepts two ascending 4-word blocks in parallel and emits their ascending
// merge as an 8-word serial burst.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; the sender holds valid and its payload stable until that edge,
// and valid never depends combinationally on ready.
module sort_merge_stream
  import sort_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] a2,
  input  logic [WIDTH-1:0] a3,
  input  logic [WIDTH-1:0] a4,
  input  logic [WIDTH-1:0] b1,
  input  logic [WIDTH-1:0] b2,
  input  logic [WIDTH-1:0] b3,
  input  logic [WIDTH-1:0] b4,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  output logic             out_last
);

  logic [0:0] r_state;
  logic       r_in_ready;
  word_t      r_a [DEPTH];
  word_t      r_b [DEPTH];
  ptr_t       r_ia;
  ptr_t       r_ib;
  logic       r_out_valid;
  word_t      r_out_data;
  logic       r_out_src;
  logic       r_out_last;

  logic       w_accept;
  logic       w_out_hs;
  ptr_t       w_ia_next;
  ptr_t       w_ib_next;
  word_t      w_cand_a;
  word_t      w_cand_b;
  logic       w_a_done;
  logic       w_b_done;
  word_t      w_pick_word;
  logic       w_pick_src;
  logic [3:0] w_sum_next;
  logic       w_last_next;

  assign w_accept  = (r_state == ST_IDLE) && in_valid && r_in_ready;
  assign w_out_hs  = r_out_valid && out_ready;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;
  assign out_last  = r_out_last;

  // Candidate heads for the word to present next. In IDLE the first word is
  // picked straight from the ports so it appears the cycle after acceptance;
  // in MERGE the pointers are advanced past the word being consumed now.
  always_comb begin
    w_ia_next = r_ia;
    w_ib_next = r_ib;
    if (r_out_src) w_ib_next = r_ib + 3'd1;
    else           w_ia_next = r_ia + 3'd1;

    if (r_state == ST_IDLE) begin
      w_cand_a = a1;
      w_cand_b = b1;
      w_a_done = 1'b0;
      w_b_done = 1'b0;
    end else begin
      w_cand_a = r_a[w_ia_next[1:0]];
      w_cand_b = r_b[w_ib_next[1:0]];
      w_a_done = (w_ia_next == PTR_END);
      w_b_done = (w_ib_next == PTR_END);
    end

    w_sum_next  = {1'b0, w_ia_next} + {1'b0, w_ib_next};
    w_last_next = (w_sum_next == 4'd7);
  end

  merge_pick u_pick (
    .cand_a (w_cand_a),
    .cand_b (w_cand_b),
    .a_done (w_a_done),
    .b_done (w_b_done),
    .word   (w_pick_word),
    .src    (w_pick_src)
  );

  // FSM, block capture, pointer advance and registered output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b0;
      r_ia        <= '0;
      r_ib        <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= 1'b0;
      r_out_last  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_a[i] <= '0;
        r_b[i] <= '0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_a[0]      <= a1;
            r_a[1]      <= a2;
            r_a[2]      <= a3;
            r_a[3]      <= a4;
            r_b[0]      <= b1;
            r_b[1]      <= b2;
            r_b[2]      <= b3;
            r_b[3]      <= b4;
            r_ia        <= '0;
            r_ib        <= '0;
            r_out_valid <= 1'b1;
            r_out_data  <= w_pick_word;
            r_out_src   <= w_pick_src;
            r_out_last  <= 1'b0;
            r_in_ready  <= 1'b0;
            r_state     <= ST_MERGE;
          end
        end
        default: begin
          r_in_ready <= 1'b0;
          if (w_out_hs) begin
            if (r_out_last) begin
              // Final word consumed: close the burst, reopen the input.
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_in_ready  <= 1'b1;
              r_state     <= ST_IDLE;
            end else begin
              r_ia       <= w_ia_next;
              r_ib       <= w_ib_next;
              r_out_data <= w_pick_word;
              r_out_src  <= w_pick_src;
              r_out_last <= w_last_next;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sort_merge_stream.sv
// Self-checking bench for sort_merge_stream: directed and random blocks,
// scoreboard fed by a queue-based merge model, output hold checks.
module tb_sort_merge_stream;

  localparam int W = 10; // {src, last, data}

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a1, a2, a3, a4, b1, b2, b3, b4;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_src;
  logic       out_last;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int hs_total = 0;
  int ready_mode = 3;
  int pat = 0;
  logic [7:0] blk_a [4];
  logic [7:0] blk_b [4];

  sort_merge_stream dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a1        (a1),
    .a2        (a2),
    .a3        (a3),
    .a4        (a4),
    .b1        (b1),
    .b2        (b2),
    .b3        (b3),
    .b4        (b4),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_last  (out_last)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Plain two-queue merge of the current blk_a/blk_b; equal heads emit A first.
  task automatic push_expected();
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [7:0] w;
    logic       s;
    for (int i = 0; i < 4; i++) begin
      qa.push_back(blk_a[i]);
      qb.push_back(blk_b[i]);
    end
    for (int k = 0; k < 8; k++) begin
      if (qa.size() > 0 && (qb.size() == 0 || qa[0] <= qb[0])) begin
        w = qa.pop_front(); s = 1'b0;
      end else begin
        w = qb.pop_front(); s = 1'b1;
      end
      exp_q.push_back({s, (k == 7), w});
    end
  endtask

  // ---------------- drivers ----------------
  task automatic set_blocks(input logic [7:0] x0, x1, x2, x3, y0, y1, y2, y3);
    blk_a[0] = x0; blk_a[1] = x1; blk_a[2] = x2; blk_a[3] = x3;
    blk_b[0] = y0; blk_b[1] = y1; blk_b[2] = y2; blk_b[3] = y3;
  endtask

  task automatic rand_blocks();
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    int hi;
    hi = ($urandom_range(0, 2) == 0) ? 3 : 255;
    for (int i = 0; i < 4; i++) begin
      qa.push_back(8'($urandom_range(0, hi)));
      qb.push_back(8'($urandom_range(0, hi)));
    end
    qa.sort();
    qb.sort();
    for (int i = 0; i < 4; i++) begin
      blk_a[i] = qa[i];
      blk_b[i] = qb[i];
    end
  endtask

  task automatic drive_ports();
    a1 = blk_a[0]; a2 = blk_a[1]; a3 = blk_a[2]; a4 = blk_a[3];
    b1 = blk_b[0]; b2 = blk_b[1]; b3 = blk_b[2]; b4 = blk_b[3];
  endtask

  // Offer blk_a/blk_b; with scramble, in_valid stays high carrying junk
  // until in_ready is seen. Returns the cycle number of acceptance.
  task automatic send_block(input bit scramble, input bit keep_valid, output int acc_cyc);
    int n;
    n = 0;
    acc_cyc = -1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      if (scramble) begin
        in_valid = 1'b1;
        {a1, a2, a3, a4} = $urandom;
        {b1, b2, b3, b4} = $urandom;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
    end else begin
      drive_ports();
      in_valid = 1'b1;
      push_expected();
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      if (!keep_valid) in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #2;
      if (exp_q.size() == 0 && !out_valid) break;
    end
    check("drain", 32'(exp_q.size() == 0 && !out_valid), 32'd1);
  endtask

  // out_ready pattern: 0 = always, 1 = random, 2 = 1,0,0,1 repeating, else 0.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      2: begin
        out_ready = (pat % 4 == 0) || (pat % 4 == 3);
        pat++;
      end
      default: out_ready = 1'b0;
    endcase
  end

  // ---------------- scoreboard / monitor ----------------
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_beat  = '0;
  logic         idle_pend  = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      idle_pend  = 1'b0;
    end else begin
      if (idle_pend) begin
        check("ready_after_last", 32'(in_ready), 32'd1);
        check("valid_after_last", 32'(out_valid), 32'd0);
        idle_pend = 1'b0;
      end
      if (prev_stall) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_beat", 32'({out_src, out_last, out_data}), 32'(prev_beat));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'({out_src, out_last, out_data}), 32'h3ff);
        end else begin
          check("beat", 32'({out_src, out_last, out_data}), 32'(exp_q.pop_front()));
        end
        hs_total++;
        if (out_last) idle_pend = 1'b1;
      end
      prev_stall = out_valid && !out_ready;
      prev_beat  = {out_src, out_last, out_data};
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int acc1, acc2, base, n;
    rst = 1'b1;
    in_valid = 1'b0;
    {a1, a2, a3, a4, b1, b2, b3, b4} = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_src", 32'(out_src), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_rst", 32'(in_ready), 32'd1);

    // 1: interleaved merge, continuous ready
    ready_mode = 0;
    set_blocks(1, 4, 6, 9, 2, 3, 7, 8);
    send_block(0, 0, acc1);
    wait_drain();

    // 2: all ties, A must drain first
    set_blocks(5, 5, 5, 5, 5, 5, 5, 5);
    send_block(0, 0, acc1);
    wait_drain();

    // 3: B entirely below A, stalled with 1,0,0,1 ready pattern
    ready_mode = 2;
    pat = 0;
    set_blocks(10, 20, 30, 40, 1, 2, 3, 4);
    send_block(0, 0, acc1);
    wait_drain();

    // 4: full-scale values, A exhausts first
    ready_mode = 0;
    set_blocks(0, 0, 0, 255, 254, 255, 255, 255);
    send_block(0, 0, acc1);
    wait_drain();

    // 5: reset after the third word
    rand_blocks();
    base = hs_total;
    send_block(0, 0, acc1);
    n = 0;
    while (hs_total < base + 3 && n < 50) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("mid_burst_progress", 32'(hs_total - base), 32'd3);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_out_data", 32'(out_data), 32'd0);
    check("abort_out_last", 32'(out_last), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    exp_q.delete();
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_abort", 32'(in_ready), 32'd1);
    check("valid_after_abort", 32'(out_valid), 32'd0);
    rand_blocks();
    send_block(0, 0, acc1);
    wait_drain();

    // 6: in_valid held high with junk during MERGE; back-to-back acceptance
    rand_blocks();
    send_block(0, 1, acc1);
    rand_blocks();
    send_block(1, 0, acc2);
    check("accept_spacing", 32'(acc2 - acc1), 32'd9);
    wait_drain();

    // Random blocks under mixed backpressure.
    for (int t = 0; t < 40; t++) begin
      ready_mode = $urandom_range(0, 2);
      rand_blocks();
      send_block(0, 0, acc1);
      if ($urandom_range(0, 1) == 1) wait_drain();
    end
    wait_drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
